// File: rtl/vga_color_sequencer.sv
// Debounces the color switches and commits color changes only on a vsync frame edge; auto mode steps colors every FRAMES_PER_STEP frames.
// Latency: vsync edge to frame_tick/color_sel is 3 clk edges; switch to stable is ~2+DEBOUNCE_CYCLES edges; no backpressure.
module vga_color_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned FRAMES_PER_STEP = 60,
   parameter logic        VSYNC_ACTIVE    = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] sw,
   input  logic       auto_en,
   input  logic       vsync,
   output logic [2:0] color_sel,
   output logic       frame_tick,
   output logic       pending
);
   localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned   FW       = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [FW-1:0] FCNT_MAX = FW'(FRAMES_PER_STEP - 1);

   typedef enum logic [1:0] {MANUAL, PENDING, AUTO} state_t;

   logic [2:0]    sw_m, sw_s;
   logic          auto_m, auto_s;
   logic          vs_m, vs_s, vs_d;
   logic          frame_edge;
   logic [2:0]    cand, stable;
   logic [CW-1:0] cnt;
   state_t        state, state_nx;
   logic [2:0]    color_nx;
   logic [FW-1:0] fcnt, fcnt_nx;

   // vsync flops reset to the inactive level so reset release never looks like a frame start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_m   <= '0;
         sw_s   <= '0;
         auto_m <= 1'b0;
         auto_s <= 1'b0;
         vs_m   <= ~VSYNC_ACTIVE;
         vs_s   <= ~VSYNC_ACTIVE;
         vs_d   <= ~VSYNC_ACTIVE;
      end else begin
         sw_m   <= sw;
         sw_s   <= sw_m;
         auto_m <= auto_en;
         auto_s <= auto_m;
         vs_m   <= vsync;
         vs_s   <= vs_m;
         vs_d   <= vs_s;
      end
   end

   assign frame_edge = (vs_s == VSYNC_ACTIVE) && (vs_d != VSYNC_ACTIVE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand   <= '0;
         stable <= '0;
         cnt    <= '0;
      end else if (sw_s != cand) begin
         cand <= sw_s;
         cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
         stable <= cand;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= MANUAL;
         color_sel  <= '0;
         fcnt       <= '0;
         frame_tick <= 1'b0;
         pending    <= 1'b0;
      end else begin
         state      <= state_nx;
         color_sel  <= color_nx;
         fcnt       <= fcnt_nx;
         frame_tick <= frame_edge;
         pending    <= (state_nx == PENDING);
      end
   end

   // auto_s wins over any pending commit, even when it coincides with a frame edge
   always_comb begin
      state_nx = state;
      color_nx = color_sel;
      fcnt_nx  = fcnt;
      unique case (state)
         MANUAL: begin
            if (auto_s) begin
               state_nx = AUTO;
               fcnt_nx  = '0;
            end else if (stable != color_sel) begin
               state_nx = PENDING;
            end
         end
         PENDING: begin
            if (auto_s) begin
               state_nx = AUTO;
               fcnt_nx  = '0;
            end else if (frame_edge) begin
               color_nx = stable;
               state_nx = MANUAL;
            end
         end
         AUTO: begin
            if (!auto_s) begin
               state_nx = MANUAL;
            end else if (frame_edge) begin
               if (fcnt == FCNT_MAX) begin
                  color_nx = color_sel + 3'd1;
                  fcnt_nx  = '0;
               end else begin
                  fcnt_nx = fcnt + 1'b1;
               end
            end
         end
         default: state_nx = MANUAL;
      endcase
   end
endmodule

// File: tb/tb_vga_color_sequencer.sv
// Bench for vga_color_sequencer: directed table, hand-written corner sequences and random stimulus against a frame/window reference model.
module tb_vga_color_sequencer;
   localparam int D   = 4;
   localparam int FPS = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] sw = 3'b000;
   logic       auto_en = 1'b0;
   logic       vs_man = 1'b1;
   logic       vs_gen = 1'b1;
   logic       vs_gen_en = 1'b0;
   logic       vsync;
   logic [2:0] color_sel;
   logic       frame_tick;
   logic       pending;

   int checks = 0;
   int errors = 0;
   int vs_ph  = 0;

   assign vsync = vs_gen_en ? vs_gen : vs_man;

   always #5 clk = ~clk;

   vga_color_sequencer #(
      .DEBOUNCE_CYCLES(D),
      .FRAMES_PER_STEP(FPS),
      .VSYNC_ACTIVE(1'b0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sw(sw),
      .auto_en(auto_en),
      .vsync(vsync),
      .color_sel(color_sel),
      .frame_tick(frame_tick),
      .pending(pending)
   );

   // free-running vsync: low for 4 of every 50 cycles
   initial begin
      forever begin
         @(negedge clk);
         vs_gen = (vs_ph < 4) ? 1'b0 : 1'b1;
         vs_ph  = (vs_ph == 49) ? 0 : vs_ph + 1;
      end
   end

   // reference model: inputs seen two edges late, stable = value held over a D+1 window
   logic [2:0] m_color, m_stable;
   logic       m_pend, m_auto, m_tick;
   int         m_frames;
   logic [2:0] m_sw1, m_sw2;
   logic       m_au1, m_au2, m_vs1, m_vs2, m_vs3;
   logic [2:0] win[$];

   task automatic model_reset();
      m_color = 3'b000; m_stable = 3'b000; m_pend = 1'b0; m_auto = 1'b0; m_tick = 1'b0;
      m_frames = 0;
      m_sw1 = 3'b000; m_sw2 = 3'b000; m_au1 = 1'b0; m_au2 = 1'b0;
      m_vs1 = 1'b1; m_vs2 = 1'b1; m_vs3 = 1'b1;
      win.delete();
   endtask

   task automatic model_step();
      logic       e;
      logic [2:0] st_old;
      bit         same;
      if (!rst_n) begin
         model_reset();
         return;
      end
      e      = (m_vs2 == 1'b0) && (m_vs3 == 1'b1);
      st_old = m_stable;
      if (m_auto) begin
         if (!m_au2) m_auto = 1'b0;
         else if (e) begin
            m_frames++;
            if (m_frames == FPS) begin
               m_color  = m_color + 3'd1;
               m_frames = 0;
            end
         end
      end else if (m_pend) begin
         if (m_au2) begin
            m_auto = 1'b1; m_pend = 1'b0; m_frames = 0;
         end else if (e) begin
            m_color = st_old; m_pend = 1'b0;
         end
      end else begin
         if (m_au2) begin
            m_auto = 1'b1; m_frames = 0;
         end else if (st_old != m_color) m_pend = 1'b1;
      end
      m_tick = e;
      win.push_back(m_sw2);
      if (win.size() > D + 1) void'(win.pop_front());
      if (win.size() == D + 1) begin
         same = 1'b1;
         foreach (win[i]) if (win[i] != m_sw2) same = 1'b0;
         if (same) m_stable = m_sw2;
      end
      m_vs3 = m_vs2; m_vs2 = m_vs1; m_vs1 = vsync;
      m_sw2 = m_sw1; m_sw1 = sw;
      m_au2 = m_au1; m_au1 = auto_en;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model{color,tick,pend}", {3'b0, color_sel, frame_tick, pending},
            {3'b0, m_color, m_tick, m_pend});
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         cycle();
         n++;
      end while (frame_tick !== 1'b1 && n < 150);
      check("tick_wait", {7'b0, frame_tick}, 8'd1);
   endtask

   typedef struct {
      logic [2:0] sw;
      logic       au;
      int         nt;
      logic [2:0] col;
      logic       pend;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int n_tick;
      int n;
      int pend_seen;
      vecs[0]  = '{3'b101, 1'b0, 0, 3'b000, 1'b1};
      vecs[1]  = '{3'b101, 1'b0, 1, 3'b101, 1'b0};
      vecs[2]  = '{3'b110, 1'b0, 1, 3'b110, 1'b0};
      vecs[3]  = '{3'b110, 1'b1, 2, 3'b111, 1'b0};
      vecs[4]  = '{3'b110, 1'b1, 2, 3'b000, 1'b0};
      vecs[5]  = '{3'b011, 1'b1, 1, 3'b000, 1'b0};
      vecs[6]  = '{3'b011, 1'b0, 0, 3'b000, 1'b1};
      vecs[7]  = '{3'b011, 1'b0, 1, 3'b011, 1'b0};
      vecs[8]  = '{3'b011, 1'b1, 1, 3'b011, 1'b0};
      vecs[9]  = '{3'b011, 1'b1, 1, 3'b100, 1'b0};
      vecs[10] = '{3'b100, 1'b0, 1, 3'b100, 1'b0};

      model_reset();
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (10) cycle();

      // glitch shorter than the debounce window
      sw = 3'b011;
      repeat (3) cycle();
      sw = 3'b000;
      pend_seen = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (pending) pend_seen++;
      end
      check("glitch_pending", 8'(pend_seen), 8'd0);
      check("glitch_color", {5'b0, color_sel}, 8'd0);

      // directed table on free-running vsync
      vs_gen_en = 1'b1;
      wait_tick();
      repeat (12) cycle();
      for (int i = 0; i < 11; i++) begin
         sw      = vecs[i].sw;
         auto_en = vecs[i].au;
         for (int t = 0; t < vecs[i].nt; t++) wait_tick();
         repeat (12) cycle();
         check($sformatf("vec%0d_color", i), {5'b0, color_sel}, {5'b0, vecs[i].col});
         check($sformatf("vec%0d_pending", i), {7'b0, pending}, {7'b0, vecs[i].pend});
      end

      // auto rising together with a frame edge while pending: no commit
      vs_man    = 1'b1;
      vs_gen_en = 1'b0;
      sw        = 3'b101;
      repeat (12) cycle();
      check("prio_pending_before", {7'b0, pending}, 8'd1);
      auto_en = 1'b1;
      vs_man  = 1'b0;
      repeat (3) cycle();
      check("prio_tick", {7'b0, frame_tick}, 8'd1);
      check("prio_no_commit", {5'b0, color_sel}, 8'd4);
      check("prio_pending_clear", {7'b0, pending}, 8'd0);
      repeat (3) cycle();
      vs_man = 1'b1;
      repeat (3) cycle();
      auto_en = 1'b0;
      repeat (5) cycle();
      check("prio_repending", {7'b0, pending}, 8'd1);
      vs_man = 1'b0;
      repeat (3) cycle();
      check("prio_commit", {5'b0, color_sel}, 8'd5);
      check("prio_commit_pend", {7'b0, pending}, 8'd0);

      // vsync held active: one tick only
      vs_man = 1'b1;
      repeat (5) cycle();
      vs_man = 1'b0;
      n_tick = 0;
      for (int i = 0; i < 200; i++) begin
         cycle();
         if (frame_tick) n_tick++;
      end
      check("held_low_ticks", 8'(n_tick), 8'd1);
      vs_man = 1'b1;
      repeat (5) cycle();

      // asynchronous reset mid-frame
      vs_gen_en = 1'b1;
      wait_tick();
      repeat (20) cycle();
      #2 rst_n = 1'b0;
      #1;
      check("rst_color", {5'b0, color_sel}, 8'd0);
      check("rst_tick", {7'b0, frame_tick}, 8'd0);
      check("rst_pending", {7'b0, pending}, 8'd0);
      repeat (3) cycle();
      rst_n  = 1'b1;
      n_tick = 0;
      n      = 0;
      while (vsync !== 1'b0 && n < 100) begin
         cycle();
         if (frame_tick) n_tick++;
         n++;
      end
      check("post_rst_spurious_tick", 8'(n_tick), 8'd0);
      wait_tick();

      // random stimulus against the model
      for (int s = 0; s < 300; s++) begin
         sw = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) auto_en = ~auto_en;
         repeat ($urandom_range(1, 10)) cycle();
      end
      auto_en = 1'b0;
      repeat (120) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
